// File: rtl/irig_frame_decoder_if.sv
// Symbol handshake and decoded-time bus between the IRIG pulse-width
// sequencer and the frame decoder.
interface irig_frame_decoder_if #(
  parameter int CNT_W = 32
);
  logic             data_ready;
  logic [CNT_W-1:0] width;
  logic             terminate;
  logic             rst;
  logic             in_frame;
  logic             cont;
  logic             locked;
  logic             time_valid;
  logic [6:0]       sec_bcd;
  logic [6:0]       min_bcd;
  logic [5:0]       hour_bcd;
  logic [9:0]       day_bcd;

  modport master (
    output data_ready, width,
    input  terminate, rst, in_frame, cont, locked, time_valid,
           sec_bcd, min_bcd, hour_bcd, day_bcd
  );

  modport slave (
    input  data_ready, width,
    output terminate, rst, in_frame, cont, locked, time_valid,
           sec_bcd, min_bcd, hour_bcd, day_bcd
  );
endinterface

// File: rtl/irig_frame_decoder.sv
// IRIG-B symbol classifier, two-marker frame sync, 100-bit position tracker
// and BCD time-of-year latch; one registered control response per symbol.
module irig_frame_decoder #(
  parameter int CNT_W = 32,
  parameter int T_MIN = 100,
  parameter int T_01  = 350,
  parameter int T_1P  = 650,
  parameter int T_MAX = 950
) (
  input  logic                 clk,
  input  logic                 hard_rst,
  irig_frame_decoder_if.slave  bus
);

  typedef enum logic [1:0] {HUNT, MARK1, FRAME} state_t;
  typedef enum logic [1:0] {SYM_ZERO, SYM_ONE, SYM_MARK, SYM_ERR} sym_t;

  // Response vector order: {terminate, rst, in_frame, cont}
  localparam logic [3:0] R_TERM = 4'b1000;
  localparam logic [3:0] R_RST  = 4'b0100;
  localparam logic [3:0] R_IN   = 4'b0010;
  localparam logic [3:0] R_CONT = 4'b0001;

  state_t      state, state_n;
  sym_t        sym;
  logic        dr_q;
  logic        evt;
  logic [6:0]  idx, idx_n;
  logic [29:0] store, store_n;
  logic [29:0] fields, fields_n;
  logic [3:0]  resp_q, resp_n;
  logic        tv_q, tv_n;
  logic        is_marker;
  logic        slot_hit;
  logic [4:0]  slot;

  assign evt = bus.data_ready & ~dr_q;

  always_comb begin
    if (bus.width < CNT_W'(T_MIN))       sym = SYM_ERR;
    else if (bus.width < CNT_W'(T_01))   sym = SYM_ZERO;
    else if (bus.width < CNT_W'(T_1P))   sym = SYM_ONE;
    else if (bus.width <= CNT_W'(T_MAX)) sym = SYM_MARK;
    else                                 sym = SYM_ERR;
  end

  assign is_marker = (idx == 7'd0) ||
                     (idx inside {7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
                                  7'd59, 7'd69, 7'd79, 7'd89, 7'd99});

  // Only field-carrying positions are kept; store is packed {day,hour,min,sec}
  // so the latch is a straight copy.
  always_comb begin
    slot_hit = 1'b1;
    slot     = '0;
    case (idx) inside
      [7'd1:7'd4]:   slot = 5'(idx - 7'd1);
      [7'd6:7'd8]:   slot = 5'(idx - 7'd2);
      [7'd10:7'd13]: slot = 5'(idx - 7'd3);
      [7'd15:7'd17]: slot = 5'(idx - 7'd4);
      [7'd20:7'd23]: slot = 5'(idx - 7'd6);
      [7'd25:7'd26]: slot = 5'(idx - 7'd7);
      [7'd30:7'd33]: slot = 5'(idx - 7'd10);
      [7'd35:7'd38]: slot = 5'(idx - 7'd11);
      [7'd40:7'd41]: slot = 5'(idx - 7'd12);
      default:       slot_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    store_n  = store;
    fields_n = fields;
    resp_n   = '0;
    tv_n     = 1'b0;
    if (evt) begin
      case (state)
        HUNT: begin
          resp_n = R_CONT;
          if (sym == SYM_MARK) state_n = MARK1;
        end
        MARK1: begin
          if (sym == SYM_MARK) begin
            state_n = FRAME;
            idx_n   = 7'd1;
            resp_n  = R_RST;
          end else begin
            state_n = HUNT;
            resp_n  = R_CONT;
          end
        end
        FRAME: begin
          if (sym == SYM_ERR || ((sym == SYM_MARK) != is_marker)) begin
            state_n = HUNT;
            resp_n  = R_TERM;
          end else begin
            resp_n = R_IN;
            if (sym != SYM_MARK && slot_hit) store_n[slot] = (sym == SYM_ONE);
            if (idx == 7'd99) begin
              fields_n = store;
              tv_n     = 1'b1;
              idx_n    = '0;
            end else begin
              idx_n = idx + 7'd1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      state  <= HUNT;
      dr_q   <= 1'b0;
      idx    <= '0;
      store  <= '0;
      fields <= '0;
      resp_q <= '0;
      tv_q   <= 1'b0;
    end else begin
      state  <= state_n;
      dr_q   <= bus.data_ready;
      idx    <= idx_n;
      store  <= store_n;
      fields <= fields_n;
      resp_q <= resp_n;
      tv_q   <= tv_n;
    end
  end

  assign bus.terminate  = resp_q[3];
  assign bus.rst        = resp_q[2];
  assign bus.in_frame   = resp_q[1];
  assign bus.cont       = resp_q[0];
  assign bus.time_valid = tv_q;
  assign bus.locked     = (state == FRAME);
  assign bus.sec_bcd    = fields[6:0];
  assign bus.min_bcd    = fields[13:7];
  assign bus.hour_bcd   = fields[19:14];
  assign bus.day_bcd    = fields[29:20];

endmodule

// File: tb/tb_irig_frame_decoder.sv
// Bench for irig_frame_decoder: threshold/sync vector table, directed frame,
// reset and held-ready sequences, then random symbols against a frame model.
module tb_irig_frame_decoder;

  localparam int T_MIN = 100;
  localparam int T_01  = 350;
  localparam int T_1P  = 650;
  localparam int T_MAX = 950;

  localparam logic [3:0] R_TERM = 4'b1000;
  localparam logic [3:0] R_RST  = 4'b0100;
  localparam logic [3:0] R_IN   = 4'b0010;
  localparam logic [3:0] R_CONT = 4'b0001;

  logic clk = 1'b0;
  logic hard_rst;

  irig_frame_decoder_if #(.CNT_W(32)) bus ();

  irig_frame_decoder #(
    .CNT_W(32), .T_MIN(T_MIN), .T_01(T_01), .T_1P(T_1P), .T_MAX(T_MAX)
  ) dut (
    .clk(clk),
    .hard_rst(hard_rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference model: frame-level view of the IRIG-B rules
  bit          m_synced;
  bit          m_prev_mark;
  int          m_pos;
  bit          m_data[100];
  logic [6:0]  m_sec, m_min;
  logic [5:0]  m_hour;
  logic [9:0]  m_day;
  logic [3:0]  e_resp;
  bit          e_tv;

  logic [3:0]  a_resp;
  logic        a_locked;
  logic        a_tv;

  typedef struct {
    int unsigned w;
    logic [3:0]  resp;
    bit          lk;
  } vec_t;
  vec_t tbl[$];

  bit fb[100];
  int unsigned fw[100];

  function automatic int classify(int unsigned w);
    if (w < T_MIN) return 3;
    if (w < T_01)  return 0;
    if (w < T_1P)  return 1;
    if (w <= T_MAX) return 2;
    return 3;
  endfunction

  function automatic int digit(int lo, int n);
    int v = 0;
    for (int k = 0; k < n; k++) v += int'(m_data[lo+k]) << k;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_synced = 0; m_prev_mark = 0; m_pos = 0;
    for (int i = 0; i < 100; i++) m_data[i] = 0;
    m_sec = '0; m_min = '0; m_hour = '0; m_day = '0;
  endtask

  task automatic model_step(input int unsigned w);
    int  cls;
    bit  marker;
    cls  = classify(w);
    e_tv = 0;
    if (!m_synced) begin
      if (m_prev_mark && cls == 2) begin
        m_synced = 1; m_pos = 1; m_prev_mark = 0; e_resp = R_RST;
      end else begin
        m_prev_mark = (cls == 2); e_resp = R_CONT;
      end
    end else begin
      marker = (m_pos == 0) || (m_pos % 10 == 9);
      if (cls == 3 || ((cls == 2) != marker)) begin
        m_synced = 0; m_prev_mark = 0; e_resp = R_TERM;
      end else begin
        e_resp = R_IN;
        if (cls != 2) m_data[m_pos] = (cls == 1);
        if (m_pos == 99) begin
          m_sec  = 7'((digit(6, 3) << 4) | digit(1, 4));
          m_min  = 7'((digit(15, 3) << 4) | digit(10, 4));
          m_hour = 6'((digit(25, 2) << 4) | digit(20, 4));
          m_day  = 10'((digit(40, 2) << 8) | (digit(35, 4) << 4) | digit(30, 4));
          e_tv   = 1;
          m_pos  = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic apply(input int unsigned w);
    @(negedge clk);
    bus.data_ready = 1'b1;
    bus.width      = w;
    model_step(w);
    @(negedge clk);
    bus.data_ready = 1'b0;
    a_resp   = {bus.terminate, bus.rst, bus.in_frame, bus.cont};
    a_locked = bus.locked;
    a_tv     = bus.time_valid;
  endtask

  task automatic check_model(input string tag);
    check({tag, " resp"}, 32'(a_resp), 32'(e_resp));
    check({tag, " locked"}, 32'(a_locked), 32'(m_synced));
    check({tag, " time_valid"}, 32'(a_tv), 32'(e_tv));
    check({tag, " fields"}, 32'({bus.sec_bcd, bus.min_bcd, bus.hour_bcd, bus.day_bcd}),
          32'({m_sec, m_min, m_hour, m_day}));
  endtask

  task automatic do_reset();
    hard_rst       = 1'b1;
    bus.data_ready = 1'b0;
    bus.width      = '0;
    repeat (2) @(negedge clk);
    hard_rst = 1'b0;
    model_reset();
  endtask

  function automatic void add(int unsigned w, logic [3:0] r, bit lk);
    vec_t v;
    v.w = w; v.resp = r; v.lk = lk;
    tbl.push_back(v);
  endfunction

  function automatic void put_digit(int lo, int n, int val);
    for (int k = 0; k < n; k++) fb[lo+k] = ((val >> k) & 1) != 0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int unsigned w;
    bit mk;

    hard_rst       = 1'b1;
    bus.data_ready = 1'b0;
    bus.width      = '0;
    model_reset();
    #1;
    check("reset outputs", 32'({bus.terminate, bus.rst, bus.in_frame, bus.cont, bus.locked,
          bus.time_valid}), 32'd0);
    check("reset fields", 32'({bus.sec_bcd, bus.min_bcd, bus.hour_bcd, bus.day_bcd}), 32'd0);
    repeat (2) @(negedge clk);
    hard_rst = 1'b0;

    // threshold / sync table
    add(50, R_CONT, 0);  add(800, R_CONT, 0); add(800, R_RST, 1);
    add(349, R_IN, 1);   add(350, R_IN, 1);   add(100, R_IN, 1);
    add(99, R_TERM, 0);
    add(950, R_CONT, 0); add(950, R_RST, 1);
    for (int i = 1; i <= 4; i++) add(300, R_IN, 1);
    add(1000, R_TERM, 0);
    add(800, R_CONT, 0); add(800, R_RST, 1);
    for (int i = 1; i <= 8; i++) add(649, R_IN, 1);
    add(650, R_IN, 1);   add(951, R_TERM, 0);
    add(800, R_CONT, 0); add(800, R_RST, 1);  add(800, R_TERM, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].w);
      check($sformatf("vec%0d resp", i), 32'(a_resp), 32'(tbl[i].resp));
      check($sformatf("vec%0d locked", i), 32'(a_locked), 32'(tbl[i].lk));
    end

    // full frame 12:34:56 day 123
    do_reset();
    for (int i = 0; i < 100; i++) fb[i] = 0;
    put_digit(1, 4, 6);  put_digit(6, 3, 5);
    put_digit(10, 4, 4); put_digit(15, 3, 3);
    put_digit(20, 4, 2); put_digit(25, 2, 1);
    put_digit(30, 4, 3); put_digit(35, 4, 2); put_digit(40, 2, 1);
    for (int i = 0; i < 100; i++)
      fw[i] = (i == 0 || i % 10 == 9) ? 800 : (fb[i] ? 500 : 200);
    apply(800);
    check("frame lead resp", 32'(a_resp), 32'(R_CONT));
    apply(fw[0]);
    check("frame sync resp", 32'(a_resp), 32'(R_RST));
    check("frame sync locked", 32'(a_locked), 32'd1);
    for (int i = 1; i < 100; i++) begin
      apply(fw[i]);
      check($sformatf("frame idx%0d resp", i), 32'(a_resp), 32'(R_IN));
      check($sformatf("frame idx%0d time_valid", i), 32'(a_tv), 32'(i == 99));
    end
    check("frame fields", 32'({bus.sec_bcd, bus.min_bcd, bus.hour_bcd, bus.day_bcd}),
          32'({7'h56, 7'h34, 6'h12, 10'h123}));
    apply(800);
    check("wrap idx0 resp", 32'(a_resp), 32'(R_IN));
    check("wrap idx0 time_valid", 32'(a_tv), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      apply(200);
      check($sformatf("post idx%0d resp", i), 32'(a_resp), 32'(R_IN));
    end
    apply(500);
    check("marker violation resp", 32'(a_resp), 32'(R_TERM));
    check("marker violation locked", 32'(a_locked), 32'd0);
    check("marker violation fields", 32'({bus.sec_bcd, bus.min_bcd, bus.hour_bcd, bus.day_bcd}),
          32'({7'h56, 7'h34, 6'h12, 10'h123}));
    apply(800);
    check("after violation resp", 32'(a_resp), 32'(R_CONT));

    // asynchronous reset while a response pulse is high
    apply(800);
    check("pre-reset sync", 32'(a_resp), 32'(R_RST));
    @(negedge clk);
    bus.data_ready = 1'b1;
    bus.width      = 200;
    @(posedge clk);
    #1;
    check("pre-reset in_frame", 32'(bus.in_frame), 32'd1);
    hard_rst = 1'b1;
    #1;
    check("async reset outputs", 32'({bus.terminate, bus.rst, bus.in_frame, bus.cont, bus.locked,
          bus.time_valid}), 32'd0);
    check("async reset fields", 32'({bus.sec_bcd, bus.min_bcd, bus.hour_bcd, bus.day_bcd}), 32'd0);
    @(negedge clk);
    bus.data_ready = 1'b0;
    hard_rst       = 1'b0;
    model_reset();
    apply(800);
    check_model("post-reset");

    // data_ready held three cycles gives a single response
    apply(800);
    check_model("held sync");
    @(negedge clk);
    bus.data_ready = 1'b1;
    bus.width      = 200;
    model_step(200);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) check("held first resp", 32'({bus.terminate, bus.rst, bus.in_frame, bus.cont}),
                        32'(R_IN));
      cnt += int'(bus.terminate) + int'(bus.rst) + int'(bus.in_frame) + int'(bus.cont);
      if (c == 2) bus.data_ready = 1'b0;
    end
    check("held response count", 32'(cnt), 32'd1);
    apply(300);
    check_model("after held");

    // random symbols against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (m_synced) begin
        mk = (m_pos == 0) || (m_pos % 10 == 9);
        if ($urandom_range(0, 299) == 0) w = $urandom_range(0, 1100);
        else if (mk)                     w = $urandom_range(T_1P, T_MAX);
        else                             w = $urandom_range(T_MIN, T_1P - 1);
      end else begin
        w = ($urandom_range(0, 3) != 0) ? $urandom_range(T_1P, T_MAX) : $urandom_range(0, 1100);
      end
      apply(w);
      check_model($sformatf("rand%0d w=%0d", n, w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
